sobel_out_streamer: RTL

Downstream read-out stage for `sobel_top`. After the Sobel engine raises `finish_o`, this block reads the output image memory sequentially through the `rd_en_omem_i`/`addr_omem_i`/`data_omem_o` port. It then emits the pixels as a valid/ready stream with end-of-line and end-of-frame markers. A 2-entry output FIFO with read-credit accounting hides the memory read latency, sustains 1 pixel/cycle and tolerates arbitrary backpressure.

---
 rtl/sobel_out_streamer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sobel_out_streamer.sv
// Read-out stage for the Sobel output memory: sequential reads after finish,
// re-emitted as a valid/ready pixel stream with end-of-line / end-of-frame tags.
module sobel_out_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  finish_i,
  output logic                  rd_en_omem_o,
  output logic [ADDR_WIDTH-1:0] addr_omem_o,
  input  logic [DATA_WIDTH-1:0] data_omem_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_eol_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int N     = IMG_W * IMG_H;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  eol;
    logic                  last;
  } beat_t;

  state_e                state_q, state_d;
  logic                  finish_q;
  logic                  start;
  logic                  rd_en_q;
  logic                  done_q;

  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic                  inflight_q;
  logic                  infl_eol_q, infl_eol_d;
  logic                  infl_last_q, infl_last_d;

  beat_t                 fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q, occ_d;
  beat_t                 head;
  beat_t                 push_beat;

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  last_hs;
  logic [2:0]            credit;

  assign start = finish_i & ~finish_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      finish_q <= 1'b0;
      rd_en_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= finish_i;
      rd_en_q  <= (state_d != IDLE);
      done_q   <= (state_q == DRAIN) && last_hs;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational block assigns a default to every output first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (issue && (rd_addr_q == LAST_ADDR)) state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and read-issue control
  // ---------------------------------------------------------------------------
  always_comb begin
    pop     = (occ_q != 2'd0) & m_ready_i;
    // Entries held or owed to the FIFO after this cycle's pop; keeps it <= 2.
    credit  = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    issue   = (state_q == STREAM) && (credit < 3'd2);
    last_hs = pop & head.last;

    addr_omem_o  = issue ? rd_addr_q : addr_q;
    rd_en_omem_o = rd_en_q;
    busy_o       = (state_q != IDLE);
    done_o       = done_q;
  end

  // ---------------------------------------------------------------------------
  // Address / column counters and in-flight tags
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_addr_d   = rd_addr_q;
    col_d       = col_q;
    addr_d      = addr_q;
    infl_eol_d  = infl_eol_q;
    infl_last_d = infl_last_q;

    if ((state_q == IDLE) && start) begin
      rd_addr_d = '0;
      col_d     = '0;
    end

    if (issue) begin
      addr_d      = rd_addr_q;
      rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
      col_d       = (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
      infl_eol_d  = (col_q == LAST_COL);
      infl_last_d = (rd_addr_q == LAST_ADDR);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_q   <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      infl_eol_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      inflight_q  <= issue;
      infl_eol_q  <= infl_eol_d;
      infl_last_q <= infl_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO
  // ---------------------------------------------------------------------------
  assign push           = inflight_q;
  assign push_beat.data = data_omem_i;
  assign push_beat.eol  = infl_eol_q;
  assign push_beat.last = infl_last_q;

  always_comb begin
    occ_d = occ_q + 2'(push) - 2'(pop);
  end

  // NOTE: the two storage entries are reset because they drive the stream
  // outputs directly, which must read zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else if ((state_q == IDLE) && start) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_beat;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign head      = fifo_q[rd_ptr_q];
  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = head.data;
  assign m_eol_o   = head.eol;
  assign m_last_o  = head.last;

endmodule
